// File: rtl/serial_complement.sv
`default_nettype none
// ============================================================================
//  Module   : serial_complement
//  Purpose  : Bit-serial 1's / 2's complementer, LSB first. Each valid input
//             bit produces one registered output bit one cycle later.
//             1's mode inverts every bit. 2's mode copies bits up to and
//             including the first 1, then inverts the rest.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset
//             in_valid   - in_data carries a valid bit this cycle
//             in_data    - serial input bit, LSB first
//             mode       - 0: 1's complement, 1: 2's complement
//                          (sampled on the first bit of a word only)
//             out_valid  - out_data is valid
//             out_data   - complemented serial bit (0 when out_valid is 0)
//             word_done  - high with the last output bit of each word
//             busy       - a word is partially received
//             out_ovf    - (SERIAL_COMP_OVF_EN only) 2's complement of the
//                          most-negative value, flagged with word_done
//  Config   : define SERIAL_COMP_OVF_EN to add the out_ovf port and logic
//  Revision : 1.0 - initial release
// ============================================================================
module serial_complement #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    input  logic mode,
    output logic out_valid,
    output logic out_data,
    output logic word_done,
    output logic busy
`ifdef SERIAL_COMP_OVF_EN
    ,
    output logic out_ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_INVERT = 2'd2
    } state_t;

    state_t          r_state_q;
    state_t          w_state_d;
    state_t          w_state_eff;
    logic [CW-1:0]   r_cnt_q;
    logic [CW-1:0]   w_cnt_d;
    logic            r_mode_q;
    logic            w_mode_d;
    logic            w_mode_eff;
    logic            w_last;
    logic            r_out_valid_q;
    logic            w_out_valid_d;
    logic            r_out_data_q;
    logic            w_out_data_d;
    logic            r_word_done_q;
    logic            w_word_done_d;
    logic            r_busy_q;
    logic            w_busy_d;
`ifdef SERIAL_COMP_OVF_EN
    logic            r_ovf_q;
    logic            w_ovf_d;
`endif

    always_comb begin
        // A bit arriving in IDLE starts a word: take mode from the port and
        // behave as if already in the word's starting state, so the first
        // bit is processed with no extra cycle.
        w_state_eff = r_state_q;
        w_mode_eff  = r_mode_q;
        if (r_state_q == ST_IDLE) begin
            w_mode_eff  = mode;
            w_state_eff = mode ? ST_COPY : ST_INVERT;
        end

        w_last = (r_cnt_q == c_CNT_LAST);

        // Defaults: hold word progress, emit nothing.
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_mode_d      = r_mode_q;
        w_out_valid_d = 1'b0;
        w_out_data_d  = 1'b0;
        w_word_done_d = 1'b0;
`ifdef SERIAL_COMP_OVF_EN
        w_ovf_d       = 1'b0;
`endif

        if (in_valid) begin
            w_mode_d      = w_mode_eff;
            w_out_valid_d = 1'b1;
            w_out_data_d  = in_data ^ (w_state_eff == ST_INVERT);
            w_word_done_d = w_last;
`ifdef SERIAL_COMP_OVF_EN
            // Still copying at a 1 MSB means the input was all zeros below
            // the sign bit: the most-negative value, which has no positive.
            w_ovf_d       = w_last && (w_state_eff == ST_COPY) && in_data;
`endif
            if (w_last) begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end else begin
                w_cnt_d   = r_cnt_q + c_CNT_ONE;
                // The first 1 is copied; everything after it is inverted.
                if (w_state_eff == ST_COPY && in_data) begin
                    w_state_d = ST_INVERT;
                end else begin
                    w_state_d = w_state_eff;
                end
            end
        end

        w_busy_d = (w_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_mode_q      <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= 1'b0;
            r_word_done_q <= 1'b0;
            r_busy_q      <= 1'b0;
`ifdef SERIAL_COMP_OVF_EN
            r_ovf_q       <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_mode_q      <= w_mode_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_word_done_q <= w_word_done_d;
            r_busy_q      <= w_busy_d;
`ifdef SERIAL_COMP_OVF_EN
            r_ovf_q       <= w_ovf_d;
`endif
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign word_done = r_word_done_q;
    assign busy      = r_busy_q;
`ifdef SERIAL_COMP_OVF_EN
    assign out_ovf   = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/serial_complement.md
SERIAL_COMPLEMENT -- requirements
Module: serial_complement

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning serial word length in bits; legal range 2..64.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: in_data carries a valid bit this cycle.
REQ-005 The module SHALL have port in_data, input, 1 bit: serial data, LSB first.
REQ-006 The module SHALL have port mode, input, 1 bit: 0 selects 1's complement, 1 selects 2's complement; sampled only on the first bit of a word.
REQ-007 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-008 The module SHALL have port out_data, output, 1 bit: complemented serial bit, LSB first.
REQ-009 The module SHALL have port word_done, output, 1 bit: pulses high together with the last output bit of each word.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a word is partially received (bit counter nonzero).

Function
REQ-011 The FSM SHALL have states IDLE, COPY and INVERT.
REQ-012 IDLE SHALL be the state between words; on in_valid in IDLE the module SHALL latch mode, and the bit counter SHALL restart at 0.
REQ-013 In 1's mode, every output bit SHALL be the inverse of the input bit, and the FSM SHALL go to INVERT on the first bit.
REQ-014 In 2's mode, bits SHALL pass unchanged while in COPY, up to and including the first 1.
REQ-015 In 2's mode, the FSM SHALL move from COPY to INVERT after that first 1, and all later bits SHALL be inverted.
REQ-016 Outputs SHALL be registered, with exactly 1 cycle latency: out_valid/out_data in cycle n+1 correspond to in_valid/in_data in cycle n.
REQ-017 When in_valid is low, the bit counter, state and latched mode SHALL hold, and out_valid SHALL be 0 the next cycle; gaps of any length are legal mid-word.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and count valid bits 0..WIDTH-1.
REQ-019 On the bit with count WIDTH-1, the counter SHALL wrap to 0, the FSM SHALL return to IDLE, and word_done SHALL be asserted with that bit's output.
REQ-020 Back-to-back words with in_valid continuously high SHALL be supported with no bubble; the first bit of word k+1 immediately follows the last bit of word k.
REQ-021 An all-zero word in 2's mode SHALL remain in COPY for the whole word and output all zeros.
REQ-022 Changing mode mid-word SHALL have no effect on the current word.
REQ-023 While out_valid is 0, out_data SHALL be 0.

Reset
REQ-024 On rst high at a rising edge of clk, the module SHALL enter state IDLE, clear the counter and latched mode, and drive out_valid, out_data, word_done, busy (and out_ovf when compiled in) to 0.
REQ-025 Reset SHALL take priority over in_valid in the same cycle.
REQ-026 A reset mid-word SHALL discard the partial word, and the next valid bit after reset SHALL be bit 0 of a new word.

Configuration
REQ-027 When macro SERIAL_COMP_OVF_EN is defined, the module SHALL add output port out_ovf, 1 bit, registered.
REQ-028 With SERIAL_COMP_OVF_EN defined, out_ovf SHALL pulse together with word_done when, in 2's mode, the state is still COPY when the last bit (MSB) arrives and that bit is 1, i.e. the input is the most-negative value.
REQ-029 Without SERIAL_COMP_OVF_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=8, mode=0, input 0x5A LSB first, continuous valid: the bench SHALL check output 0xA5, out_valid for 8 cycles starting 1 cycle after the first bit, and word_done on the 8th output.
REQ-031 WIDTH=8, mode=1, input 0x14: the bench SHALL check output 0xEC (bits 0..2 copied, rest inverted); then input 0x00 SHALL give output 0x00.
REQ-032 With SERIAL_COMP_OVF_EN, WIDTH=8, mode=1, input 0x80: the bench SHALL check output 0x80 with out_ovf=1 on the word_done cycle; input 0x81 SHALL give output 0x7F with out_ovf=0.
REQ-033 WIDTH=8, mode=1, input 0x14 with in_valid low for 3 cycles after bit 3, and mode toggled during the gap: the bench SHALL check output 0xEC, no out_valid during the gap, and busy high throughout.
REQ-034 Back-to-back words 0x01 (mode=1) then 0x0F (mode=0): the bench SHALL check outputs 0xFF then 0xF0 with no idle cycle between them and two word_done pulses 8 cycles apart.
REQ-035 rst asserted after 5 bits of a word: the bench SHALL check that all outputs are 0 the next cycle, then that a fresh 0x5A in mode=0 outputs 0xA5 with correct word_done alignment.
